// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified memory port arbiter: FSM state encoding,
// requester IDs and the read-latency ceiling imposed by the 3-bit wait counter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic REQ_CORE = 1'b0;
  localparam logic REQ_DMA  = 1'b1;

  localparam int RD_LAT_MAX = 7;

  // One-hot pulse vector for a requester ID
  function automatic logic [1:0] id_onehot(input logic id);
    return id ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational two-way winner select.
// Build option MEM_ARB_RR_EN: when defined, a tie goes to the requester that
// did not win last time; when undefined, the core always wins a tie.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
`ifdef MEM_ARB_RR_EN
  input  logic       last_win,
`endif
  output logic       win
);

  // Single requester wins outright; a tie is settled by the build policy
  always_comb begin
    win = REQ_CORE;
    if (req == 2'b10) begin
      win = REQ_DMA;
    end else if (req == 2'b11) begin
`ifdef MEM_ARB_RR_EN
      win = ~last_win;
`else
      win = REQ_CORE;
`endif
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing the single instruction/data memory port between the core
// control path (requester 0) and the DMA boot loader (requester 1).
// One transaction in flight; all outputs are registered alongside the FSM.
// Build option MEM_ARB_RR_EN selects round-robin tie breaking (see mem_arb_pick).
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW     = 10,
  parameter int RD_LAT = 1
) (
  input  logic          cclk,
  input  logic          rstb,
  input  logic [1:0]    req,
  input  logic [1:0]    we,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [31:0]   wdata0,
  input  logic [31:0]   wdata1,
  output logic [1:0]    gnt,
  output logic [1:0]    rvalid,
  output logic [31:0]   rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  output logic          busy
);

  // Latency clamped into the range the 3-bit counter can represent
  localparam int          LAT_CL = (RD_LAT < 1) ? 1 :
                                   (RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT;
  localparam logic [2:0]  LAT_C  = 3'(LAT_CL);

  state_t     state;
  logic       owner;
  logic       cur_we;
  logic [2:0] cnt;
  logic       win;

`ifdef MEM_ARB_RR_EN
  logic       last_win;

  mem_arb_pick u_pick (
    .req      (req),
    .last_win (last_win),
    .win      (win)
  );
`else
  mem_arb_pick u_pick (
    .req (req),
    .win (win)
  );
`endif

  // Arbitration FSM; memory bus, pulses and busy are registered with the state
  always_ff @(posedge cclk or posedge rstb) begin
    if (rstb) begin
      state     <= IDLE;
      owner     <= REQ_CORE;
      cur_we    <= 1'b0;
      cnt       <= 3'd0;
      gnt       <= 2'b00;
      rvalid    <= 2'b00;
      rdata     <= 32'd0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= 32'd0;
      busy      <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_win  <= REQ_DMA;
`endif
    end else begin
      gnt    <= 2'b00;
      rvalid <= 2'b00;
      mem_en <= 1'b0;
      mem_we <= 1'b0;
      case (state)
        IDLE: begin
          if (req != 2'b00) begin
            owner     <= win;
            cur_we    <= we[win];
            mem_addr  <= win ? addr1 : addr0;
            mem_wdata <= win ? wdata1 : wdata0;
            mem_en    <= 1'b1;
            mem_we    <= we[win];
            gnt       <= id_onehot(win);
            busy      <= 1'b1;
            state     <= ISSUE;
`ifdef MEM_ARB_RR_EN
            last_win  <= win;
`endif
          end
        end
        ISSUE: begin
          if (cur_we) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt   <= 3'd1;
            state <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == LAT_C) begin
            rdata  <= mem_rdata;
            rvalid <= id_onehot(owner);
            state  <= RESP;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        RESP: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (read latency 1 and 3) each with a
// behavioural memory that only presents valid read data in the correct cycle.
// Honours MEM_ARB_RR_EN for tie expectations.
module tb_mem_port_arbiter;

  logic clk;
  logic rst;

  logic [1:0]  req       [2];
  logic [1:0]  we        [2];
  logic [9:0]  addr0     [2];
  logic [9:0]  addr1     [2];
  logic [31:0] wdata0    [2];
  logic [31:0] wdata1    [2];
  logic [1:0]  gnt       [2];
  logic [1:0]  rvalid    [2];
  logic [31:0] rdata     [2];
  logic        mem_en    [2];
  logic        mem_we    [2];
  logic [9:0]  mem_addr  [2];
  logic [31:0] mem_wdata [2];
  logic [31:0] mem_rdata [2];
  logic        busy      [2];

  int errors = 0;
  int checks = 0;
  int tick   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(10), .RD_LAT(1)) u_lat1 (
    .cclk(clk), .rstb(rst), .req(req[0]), .we(we[0]),
    .addr0(addr0[0]), .addr1(addr1[0]), .wdata0(wdata0[0]), .wdata1(wdata1[0]),
    .gnt(gnt[0]), .rvalid(rvalid[0]), .rdata(rdata[0]),
    .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]),
    .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0]), .busy(busy[0])
  );

  mem_port_arbiter #(.AW(10), .RD_LAT(3)) u_lat3 (
    .cclk(clk), .rstb(rst), .req(req[1]), .we(we[1]),
    .addr0(addr0[1]), .addr1(addr1[1]), .wdata0(wdata0[1]), .wdata1(wdata1[1]),
    .gnt(gnt[1]), .rvalid(rvalid[1]), .rdata(rdata[1]),
    .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]),
    .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1]), .busy(busy[1])
  );

  // Memory model: data appears only RD_LAT cycles after the strobe, junk otherwise
  logic [31:0] store [2][1024];
  logic [31:0] pipe  [2][8];

  always @(posedge clk) begin
    tick <= tick + 1;
    for (int i = 0; i < 2; i++) begin
      if (mem_en[i] && mem_we[i]) store[i][mem_addr[i]] <= mem_wdata[i];
      pipe[i][0] <= (mem_en[i] && !mem_we[i]) ? store[i][mem_addr[i]]
                                                : (32'hBAD0_0000 | 32'(tick));
      for (int k = 1; k < 8; k++) pipe[i][k] <= pipe[i][k-1];
    end
  end

  assign mem_rdata[0] = pipe[0][0];
  assign mem_rdata[1] = pipe[1][2];

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int i, input logic [1:0] r, input logic [1:0] w,
                       input logic [9:0] a0, input logic [9:0] a1,
                       input logic [31:0] d0, input logic [31:0] d1);
    req[i] = r; we[i] = w; addr0[i] = a0; addr1[i] = a1; wdata0[i] = d0; wdata1[i] = d1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) drive(i, 2'b00, 2'b00, 10'd0, 10'd0, 32'd0, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  typedef struct packed {
    logic [1:0]  req;
    logic [1:0]  we;
    logic [9:0]  a0;
    logic [9:0]  a1;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [1:0]  e_gnt;
    logic        e_we;
    logic [9:0]  e_addr;
    logic [31:0] e_data;
  } vec_t;

  vec_t tbl [6];

  // One isolated transaction from idle: grant/bus at N+1, then write done or read returned
  task automatic apply_vec(input int i, input vec_t v);
    string p;
    p = $sformatf("i%0d", i);
    drive(i, v.req, v.we, v.a0, v.a1, v.d0, v.d1);
    step();
    chk({p, " gnt"}, 32'(gnt[i]), 32'(v.e_gnt));
    chk({p, " mem_en"}, 32'(mem_en[i]), 32'd1);
    chk({p, " mem_we"}, 32'(mem_we[i]), 32'(v.e_we));
    chk({p, " mem_addr"}, 32'(mem_addr[i]), 32'(v.e_addr));
    if (v.e_we) chk({p, " mem_wdata"}, mem_wdata[i], v.e_data);
    req[i] = 2'b00;
    if (v.e_we) begin
      step();
      chk({p, " busy after write"}, 32'(busy[i]), 32'd0);
      chk({p, " gnt after write"}, 32'(gnt[i]), 32'd0);
    end else begin
      for (int k = 0; k < lat_of(i); k++) begin
        step();
        chk({p, " rvalid in wait"}, 32'(rvalid[i]), 32'd0);
        chk({p, " gnt in wait"}, 32'(gnt[i]), 32'd0);
        chk({p, " mem_en in wait"}, 32'(mem_en[i]), 32'd0);
      end
      step();
      chk({p, " rvalid"}, 32'(rvalid[i]), 32'(v.e_gnt));
      chk({p, " rdata"}, rdata[i], v.e_data);
      step();
      chk({p, " busy after read"}, 32'(busy[i]), 32'd0);
      chk({p, " rvalid after read"}, 32'(rvalid[i]), 32'd0);
    end
  endtask

  // Random traffic checked against a transaction-level timing and data model
  task automatic run_random(input int i, input int ncyc);
    int          cyc, free_at, rv_at, lat;
    logic [1:0]  rv_owner, exp_gnt, a_req, a_we, p_req, p_we;
    logic [31:0] rv_data, ed;
    logic [9:0]  ea;
    logic        ew, w, lastw;
    logic        known [1024];
    logic [31:0] gold  [1024];
    logic [9:0]  a_addr [2];
    logic [31:0] a_d    [2];
    logic [9:0]  p_addr [2];
    logic [31:0] p_d    [2];
    string       p;
    p = $sformatf("rnd i%0d", i);
    lat = lat_of(i);
    for (int k = 0; k < 1024; k++) begin known[k] = 1'b0; gold[k] = 32'd0; end
    do_reset();
    cyc = 0; free_at = 0; rv_at = -1; rv_owner = 2'b00; rv_data = 32'd0; lastw = 1'b1;
    a_req = 2'b00; a_we = 2'b00; p_req = 2'b00; p_we = 2'b00;
    ew = 1'b0; ea = 10'd0; ed = 32'd0;
    for (int r = 0; r < 2; r++) begin a_addr[r] = 10'd0; a_d[r] = 32'd0; p_addr[r] = 10'd0; p_d[r] = 32'd0; end
    for (int n = 0; n < ncyc; n++) begin
      step();
      cyc++;
      exp_gnt = 2'b00;
      if ((cyc - 1 >= free_at) && (p_req != 2'b00)) begin
        if (p_req == 2'b01) w = 1'b0;
        else if (p_req == 2'b10) w = 1'b1;
        else begin
`ifdef MEM_ARB_RR_EN
          w = ~lastw;
`else
          w = 1'b0;
`endif
        end
        lastw   = w;
        exp_gnt = w ? 2'b10 : 2'b01;
        ew = p_we[w]; ea = p_addr[w]; ed = p_d[w];
        if (ew) begin
          gold[ea] = ed; known[ea] = 1'b1; free_at = cyc + 1;
        end else begin
          free_at = cyc + lat + 2; rv_at = cyc + lat + 1; rv_owner = exp_gnt; rv_data = gold[ea];
        end
      end
      chk({p, " gnt"}, 32'(gnt[i]), 32'(exp_gnt));
      chk({p, " mem_en"}, 32'(mem_en[i]), 32'(exp_gnt != 2'b00));
      if (exp_gnt != 2'b00) begin
        chk({p, " mem_we"}, 32'(mem_we[i]), 32'(ew));
        chk({p, " mem_addr"}, 32'(mem_addr[i]), 32'(ea));
        if (ew) chk({p, " mem_wdata"}, mem_wdata[i], ed);
      end
      chk({p, " rvalid"}, 32'(rvalid[i]), (cyc == rv_at) ? 32'(rv_owner) : 32'd0);
      if (cyc == rv_at) chk({p, " rdata"}, rdata[i], rv_data);
      chk({p, " busy"}, 32'(busy[i]), 32'(cyc < free_at));
      for (int r = 0; r < 2; r++) begin
        if (exp_gnt[r] && ($urandom_range(0, 3) != 0)) begin
          a_req[r] = 1'b0;
        end else if (a_req[r] && !exp_gnt[r]) begin
          if ($urandom_range(0, 19) == 0) a_req[r] = 1'b0;
        end else if (exp_gnt[r] || ($urandom_range(0, 2) == 0)) begin
          a_req[r]  = 1'b1;
          a_addr[r] = 10'($urandom_range(0, 31));
          a_we[r]   = known[a_addr[r]] ? 1'($urandom_range(0, 1)) : 1'b1;
          a_d[r]    = $urandom;
        end
      end
      drive(i, a_req, a_we, a_addr[0], a_addr[1], a_d[0], a_d[1]);
      p_req = a_req; p_we = a_we;
      for (int r = 0; r < 2; r++) begin p_addr[r] = a_addr[r]; p_d[r] = a_d[r]; end
    end
    drive(i, 2'b00, 2'b00, 10'd0, 10'd0, 32'd0, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] tie_exp [4];

    tbl[0] = '{2'b10, 2'b10, 10'h000, 10'h3FF, 32'h0, 32'h12345678, 2'b10, 1'b1, 10'h3FF, 32'h12345678};
    tbl[1] = '{2'b10, 2'b10, 10'h000, 10'h004, 32'h0, 32'hDEADBEEF, 2'b10, 1'b1, 10'h004, 32'hDEADBEEF};
    tbl[2] = '{2'b01, 2'b00, 10'h004, 10'h000, 32'h0, 32'h0,         2'b01, 1'b0, 10'h004, 32'hDEADBEEF};
    tbl[3] = '{2'b01, 2'b01, 10'h155, 10'h000, 32'hA5A5A5A5, 32'h0,  2'b01, 1'b1, 10'h155, 32'hA5A5A5A5};
    tbl[4] = '{2'b10, 2'b00, 10'h000, 10'h155, 32'h0, 32'h0,         2'b10, 1'b0, 10'h155, 32'hA5A5A5A5};
    tbl[5] = '{2'b01, 2'b00, 10'h3FF, 10'h000, 32'h0, 32'h0,         2'b01, 1'b0, 10'h3FF, 32'h12345678};

`ifdef MEM_ARB_RR_EN
    tie_exp[0] = 2'b01; tie_exp[1] = 2'b10; tie_exp[2] = 2'b01; tie_exp[3] = 2'b10;
`else
    tie_exp[0] = 2'b01; tie_exp[1] = 2'b01; tie_exp[2] = 2'b01; tie_exp[3] = 2'b01;
`endif

    // Reset state of both instances
    do_reset();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("i%0d reset gnt", i), 32'(gnt[i]), 32'd0);
      chk($sformatf("i%0d reset rvalid", i), 32'(rvalid[i]), 32'd0);
      chk($sformatf("i%0d reset rdata", i), rdata[i], 32'd0);
      chk($sformatf("i%0d reset mem_en", i), 32'(mem_en[i]), 32'd0);
      chk($sformatf("i%0d reset mem_we", i), 32'(mem_we[i]), 32'd0);
      chk($sformatf("i%0d reset mem_addr", i), 32'(mem_addr[i]), 32'd0);
      chk($sformatf("i%0d reset busy", i), 32'(busy[i]), 32'd0);
    end

    // Table of isolated transactions on both latencies
    for (int i = 0; i < 2; i++)
      for (int t = 0; t < 6; t++) apply_vec(i, tbl[t]);

    // Tie held across four back-to-back writes after reset
    for (int i = 0; i < 2; i++) begin
      do_reset();
      drive(i, 2'b11, 2'b11, 10'h010, 10'h020, 32'h1111_0000, 32'h2222_0000);
      for (int t = 0; t < 4; t++) begin
        step();
        chk($sformatf("i%0d tie gnt %0d", i, t), 32'(gnt[i]), 32'(tie_exp[t]));
        chk($sformatf("i%0d tie addr %0d", i, t), 32'(mem_addr[i]),
            (tie_exp[t] == 2'b01) ? 32'h010 : 32'h020);
        step();
        chk($sformatf("i%0d tie gap %0d", i, t), 32'(gnt[i]), 32'd0);
      end
      req[i] = 2'b00;
      step();
    end

    // Reset while ISSUE is driving the bus
    do_reset();
    drive(0, 2'b01, 2'b00, 10'h004, 10'h000, 32'h0, 32'h0);
    step();
    req[0] = 2'b00;
    chk("issue gnt before reset", 32'(gnt[0]), 32'b01);
    #3 rst = 1'b1;
    #1;
    chk("reset in issue mem_en", 32'(mem_en[0]), 32'd0);
    chk("reset in issue gnt", 32'(gnt[0]), 32'd0);
    chk("reset in issue busy", 32'(busy[0]), 32'd0);
    @(negedge clk) rst = 1'b0;

    // Reset while WAITing for read data, then a clean request afterwards
    step();
    drive(1, 2'b01, 2'b00, 10'h004, 10'h000, 32'h0, 32'h0);
    step();
    req[1] = 2'b00;
    step();
    #3 rst = 1'b1;
    #1;
    chk("reset in wait mem_en", 32'(mem_en[1]), 32'd0);
    chk("reset in wait gnt", 32'(gnt[1]), 32'd0);
    chk("reset in wait rvalid", 32'(rvalid[1]), 32'd0);
    chk("reset in wait busy", 32'(busy[1]), 32'd0);
    @(negedge clk) rst = 1'b0;
    step();
    chk("post reset idle gnt", 32'(gnt[1]), 32'd0);
    drive(1, 2'b01, 2'b01, 10'h040, 10'h000, 32'hCAFE_F00D, 32'h0);
    step();
    chk("post reset gnt", 32'(gnt[1]), 32'b01);
    req[1] = 2'b00;
    for (int k = 0; k < 6; k++) begin
      step();
      chk("aborted read rvalid", 32'(rvalid[1]), 32'd0);
    end

    // Request pulse that never spans an edge
    drive(0, 2'b01, 2'b01, 10'h050, 10'h000, 32'h5, 32'h0);
    #3 req[0] = 2'b00;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("glitch req gnt", 32'(gnt[0]), 32'd0);
      chk("glitch req busy", 32'(busy[0]), 32'd0);
    end

    // DMA request raised and dropped while a read is waiting
    drive(1, 2'b01, 2'b00, 10'h040, 10'h000, 32'h0, 32'h0);
    step();
    chk("wait-req core gnt", 32'(gnt[1]), 32'b01);
    req[1] = 2'b00;
    step();
    req[1] = 2'b10;
    step();
    req[1] = 2'b00;
    chk("wait-req gnt mid", 32'(gnt[1]), 32'd0);
    step();
    chk("wait-req gnt late", 32'(gnt[1]), 32'd0);
    step();
    chk("wait-req rvalid", 32'(rvalid[1]), 32'b01);
    chk("wait-req rdata", rdata[1], 32'hCAFE_F00D);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("dropped req gnt", 32'(gnt[1]), 32'd0);
    end

    // Randomised traffic on both latencies
    run_random(0, 400);
    run_random(1, 400);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
